mem_stage: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline. It sits between the execute/memory pipeline register and the memory/write-back pipeline register. It consumes `pip_reg_exe_mem_t`, performs LOAD/STORE accesses to the data cache with byte-lane formatting and sign or zero extension, and detects misaligned accesses. It produces `pip_reg_mem_wb_t` for write-back, and holds at most one instruction at a time.

---
 rtl/_pkg_riscv_defines.sv | 55 +++++
 rtl/mem_align.sv | 78 +++++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/_pkg_riscv_defines.sv
// Shared RV32I pipeline definitions: opcodes, funct3 encodings, pipeline
// register layouts and the memory-stage FSM/dcache request types.
package _pkg_riscv_defines;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_fun3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_fun3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } mem_stage_state_t;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [4:0]            rd_addr;
  } pip_reg_exe_mem_t;

  typedef struct packed {
    logic [6:0]            opcode;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [4:0]            rd_addr;
  } pip_reg_mem_wb_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } dcache_req_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the memory stage: store lane replication
// and strobes, misaligned/illegal detection (request side), and load byte
// extraction with sign/zero extension (response side).
module mem_align
  import _pkg_riscv_defines::*;
(
  input  logic [6:0]  i_req_opcode,
  input  logic [2:0]  i_req_funct3,
  input  logic [1:0]  i_req_addr_lo,
  input  logic [31:0] i_req_rs2,
  input  logic [2:0]  i_rsp_funct3,
  input  logic [1:0]  i_rsp_addr_lo,
  input  logic [31:0] i_rsp_rdata,
  output logic        o_req_is_load,
  output logic        o_req_is_store,
  output logic        o_req_bad,
  output logic [31:0] o_req_wdata,
  output logic [3:0]  o_req_wstrb,
  output logic [31:0] o_load_data
);

  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_sh;

  assign o_req_is_load  = (i_req_opcode == OPC_LOAD);
  assign o_req_is_store = (i_req_opcode == OPC_STORE);
  assign o_req_bad      = w_illegal | w_misalign;

  // Request side: classify the incoming access and format store lanes.
  always_comb begin
    w_illegal   = 1'b0;
    w_misalign  = 1'b0;
    o_req_wdata = '0;
    o_req_wstrb = '0;
    if (o_req_is_load) begin
      case (load_fun3_t'(i_req_funct3))
        LB, LBU: w_misalign = 1'b0;
        LH, LHU: w_misalign = i_req_addr_lo[0];
        LW:      w_misalign = |i_req_addr_lo;
        default: w_illegal  = 1'b1;
      endcase
    end else if (o_req_is_store) begin
      case (store_fun3_t'(i_req_funct3))
        SB: begin
          o_req_wdata = {4{i_req_rs2[7:0]}};
          o_req_wstrb = 4'b0001 << i_req_addr_lo;
        end
        SH: begin
          w_misalign  = i_req_addr_lo[0];
          o_req_wdata = {2{i_req_rs2[15:0]}};
          o_req_wstrb = 4'b0011 << i_req_addr_lo;
        end
        SW: begin
          w_misalign  = |i_req_addr_lo;
          o_req_wdata = i_req_rs2;
          o_req_wstrb = 4'b1111;
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_sh = i_rsp_rdata >> {i_rsp_addr_lo, 3'b000};

  // Response side: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    o_load_data = w_sh;
    case (load_fun3_t'(i_rsp_funct3))
      LB:      o_load_data = {{24{w_sh[7]}}, w_sh[7:0]};
      LBU:     o_load_data = {24'h0, w_sh[7:0]};
      LH:      o_load_data = {{16{w_sh[15]}}, w_sh[15:0]};
      LHU:     o_load_data = {16'h0, w_sh[15:0]};
      default: o_load_data = w_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: holds one instruction, issues at most one dcache
// request for it and presents the result to write-back.
module mem_stage
  import _pkg_riscv_defines::*;
(
  input  logic             clk,
  input  logic             rst,
  input  pip_reg_exe_mem_t exe_mem_i,
  input  logic [2:0]       exe_mem_funct3_i,
  input  logic             exe_mem_valid_i,
  output logic             exe_mem_ready_o,
  output logic             dc_req_valid_o,
  input  logic             dc_req_ready_i,
  output logic [31:0]      dc_addr_o,
  output logic             dc_we_o,
  output logic [31:0]      dc_wdata_o,
  output logic [3:0]       dc_wstrb_o,
  input  logic             dc_resp_valid_i,
  input  logic [31:0]      dc_rdata_i,
  output pip_reg_mem_wb_t  mem_wb_o,
  output logic             mem_wb_valid_o,
  input  logic             mem_wb_ready_i,
  output logic             misalign_o
);

  mem_stage_state_t r_state, w_state_d, w_issue_state;
  pip_reg_mem_wb_t  r_mem_wb, w_mem_wb_d;
  dcache_req_t      r_dc_req;

  logic [6:0]  r_opcode;
  logic [31:0] r_pc_plus4;
  logic [31:0] r_alu_result;
  logic [4:0]  r_rd_addr;
  logic [2:0]  r_funct3;
  logic        r_misalign;

  logic        w_accept;
  logic        w_in_req;
  logic        w_req_is_load;
  logic        w_req_is_store;
  logic        w_req_bad;
  logic [31:0] w_req_wdata;
  logic [3:0]  w_req_wstrb;
  logic [31:0] w_load_data;
  logic        w_r_is_load;

  mem_align u_mem_align (
    .i_req_opcode   (exe_mem_i.opcode),
    .i_req_funct3   (exe_mem_funct3_i),
    .i_req_addr_lo  (exe_mem_i.alu_result[1:0]),
    .i_req_rs2      (exe_mem_i.rs2_data),
    .i_rsp_funct3   (r_funct3),
    .i_rsp_addr_lo  (r_alu_result[1:0]),
    .i_rsp_rdata    (dc_rdata_i),
    .o_req_is_load  (w_req_is_load),
    .o_req_is_store (w_req_is_store),
    .o_req_bad      (w_req_bad),
    .o_req_wdata    (w_req_wdata),
    .o_req_wstrb    (w_req_wstrb),
    .o_load_data    (w_load_data)
  );

  assign exe_mem_ready_o = (r_state == S_IDLE) | ((r_state == S_OUT) & mem_wb_ready_i);
  assign w_accept        = exe_mem_valid_i & exe_mem_ready_o;
  assign w_r_is_load     = (r_opcode == OPC_LOAD);

  // Request fields are gated by state so they read zero outside S_REQ.
  assign w_in_req       = (r_state == S_REQ);
  assign dc_req_valid_o = w_in_req;
  assign dc_addr_o      = w_in_req ? r_dc_req.addr  : '0;
  assign dc_we_o        = w_in_req & r_dc_req.we;
  assign dc_wdata_o     = w_in_req ? r_dc_req.wdata : '0;
  assign dc_wstrb_o     = w_in_req ? r_dc_req.wstrb : '0;

  assign mem_wb_o       = r_mem_wb;
  assign mem_wb_valid_o = (r_state == S_OUT);
  assign misalign_o     = r_misalign;

  // Next state and next write-back payload.
  always_comb begin
    w_state_d  = r_state;
    w_mem_wb_d = r_mem_wb;
    // Bad accesses skip the dcache entirely.
    w_issue_state = ((w_req_is_load | w_req_is_store) & ~w_req_bad) ? S_REQ : S_OUT;

    case (r_state)
      S_IDLE: if (w_accept) w_state_d = w_issue_state;
      S_REQ:  if (dc_req_ready_i) w_state_d = S_WAIT;
      S_WAIT: if (dc_resp_valid_i) w_state_d = S_OUT;
      S_OUT: begin
        if (mem_wb_ready_i) w_state_d = w_accept ? w_issue_state : S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase

    if (w_accept && (w_issue_state == S_OUT)) begin
      w_mem_wb_d.opcode     = exe_mem_i.opcode;
      w_mem_wb_d.pc_plus4   = exe_mem_i.pc_plus4;
      w_mem_wb_d.alu_result = exe_mem_i.alu_result;
      w_mem_wb_d.mem_data   = '0;
      w_mem_wb_d.rd_addr    = (w_req_bad | w_req_is_store) ? 5'd0 : exe_mem_i.rd_addr;
    end else if ((r_state == S_WAIT) && dc_resp_valid_i) begin
      w_mem_wb_d.opcode     = r_opcode;
      w_mem_wb_d.pc_plus4   = r_pc_plus4;
      w_mem_wb_d.alu_result = r_alu_result;
      w_mem_wb_d.mem_data   = w_r_is_load ? w_load_data : '0;
      w_mem_wb_d.rd_addr    = w_r_is_load ? r_rd_addr : 5'd0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_d;
  end

  // Latch the accepted instruction, its dcache request and the output payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode     <= '0;
      r_pc_plus4   <= '0;
      r_alu_result <= '0;
      r_rd_addr    <= '0;
      r_funct3     <= '0;
      r_dc_req     <= '0;
      r_mem_wb     <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_mem_wb   <= w_mem_wb_d;
      r_misalign <= w_accept & w_req_bad;
      if (w_accept) begin
        r_opcode       <= exe_mem_i.opcode;
        r_pc_plus4     <= exe_mem_i.pc_plus4;
        r_alu_result   <= exe_mem_i.alu_result;
        r_rd_addr      <= exe_mem_i.rd_addr;
        r_funct3       <= exe_mem_funct3_i;
        r_dc_req.addr  <= {exe_mem_i.alu_result[31:2], 2'b00};
        r_dc_req.we    <= w_req_is_store;
        r_dc_req.wdata <= w_req_wdata;
        r_dc_req.wstrb <= w_req_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import _pkg_riscv_defines::*;

  localparam logic [6:0] OPC_ADD = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst;
  pip_reg_exe_mem_t exe_mem_i;
  logic [2:0]       exe_mem_funct3_i;
  logic             exe_mem_valid_i;
  logic             exe_mem_ready_o;
  logic             dc_req_valid_o;
  logic             dc_req_ready_i;
  logic [31:0]      dc_addr_o;
  logic             dc_we_o;
  logic [31:0]      dc_wdata_o;
  logic [3:0]       dc_wstrb_o;
  logic             dc_resp_valid_i;
  logic [31:0]      dc_rdata_i;
  pip_reg_mem_wb_t  mem_wb_o;
  logic             mem_wb_valid_o;
  logic             mem_wb_ready_i;
  logic             misalign_o;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exe_mem_i        (exe_mem_i),
    .exe_mem_funct3_i (exe_mem_funct3_i),
    .exe_mem_valid_i  (exe_mem_valid_i),
    .exe_mem_ready_o  (exe_mem_ready_o),
    .dc_req_valid_o   (dc_req_valid_o),
    .dc_req_ready_i   (dc_req_ready_i),
    .dc_addr_o        (dc_addr_o),
    .dc_we_o          (dc_we_o),
    .dc_wdata_o       (dc_wdata_o),
    .dc_wstrb_o       (dc_wstrb_o),
    .dc_resp_valid_i  (dc_resp_valid_i),
    .dc_rdata_i       (dc_rdata_i),
    .mem_wb_o         (mem_wb_o),
    .mem_wb_valid_o   (mem_wb_valid_o),
    .mem_wb_ready_i   (mem_wb_ready_i),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  // Load vectors against rdata 0x80FF7F01.
  logic [2:0]  ld_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000};
  logic [31:0] ld_addr [7] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2000,
                               32'h2001};
  logic [31:0] ld_exp  [7] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF,
                               32'h80FF_7F01, 32'h0000_0001, 32'h0000_007F};

  // Misaligned / illegal vectors.
  logic [6:0]  bad_op   [5] = '{OPC_LOAD, OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_STORE};
  logic [2:0]  bad_f3   [5] = '{3'b010, 3'b001, 3'b011, 3'b001, 3'b011};
  logic [31:0] bad_addr [5] = '{32'h2001, 32'h2003, 32'h2000, 32'h1001, 32'h1000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd);
    exe_mem_i.opcode     = op;
    exe_mem_i.pc_plus4   = 32'h0000_0104;
    exe_mem_i.alu_result = alu;
    exe_mem_i.rs2_data   = rs2;
    exe_mem_i.rd_addr    = rd;
    exe_mem_funct3_i     = f3;
    exe_mem_valid_i      = 1'b1;
  endtask

  // Offer one instruction for exactly one edge (stage must be ready).
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                      input logic [31:0] rs2, input logic [4:0] rd);
    drive(op, f3, alu, rs2, rd);
    tick();
    exe_mem_valid_i = 1'b0;
  endtask

  // From S_REQ: grant the request, then respond one cycle later.
  task automatic serve(input logic [31:0] rdata);
    dc_req_ready_i = 1'b1;
    tick();
    dc_req_ready_i  = 1'b0;
    dc_resp_valid_i = 1'b1;
    dc_rdata_i      = rdata;
    tick();
    dc_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (exe_mem_ready_o !== 1'b1) begin bad++;
      $display("FAIL rst_ready: got %b want 1", exe_mem_ready_o); end
    total++; if ({dc_req_valid_o, dc_we_o, mem_wb_valid_o, misalign_o} !== 4'b0) begin bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {dc_req_valid_o, dc_we_o, mem_wb_valid_o, misalign_o}); end
    total++; if ({dc_addr_o, dc_wdata_o, dc_wstrb_o} !== 68'h0) begin bad++;
      $display("FAIL rst_dc: got %h want 0", {dc_addr_o, dc_wdata_o, dc_wstrb_o}); end
    total++; if (mem_wb_o !== '0) begin bad++;
      $display("FAIL rst_mem_wb: got %h want 0", mem_wb_o); end
  endtask

  task automatic test_passthrough();
    send(OPC_ADD, 3'b000, 32'h1234, 32'h0, 5'd5);
    total++; if (mem_wb_valid_o !== 1'b1) begin bad++;
      $display("FAIL pt_valid: got %b want 1", mem_wb_valid_o); end
    total++; if (dc_req_valid_o !== 1'b0) begin bad++;
      $display("FAIL pt_noreq: got %b want 0", dc_req_valid_o); end
    total++; if (mem_wb_o.mem_data !== 32'h0 || mem_wb_o.rd_addr !== 5'd5) begin bad++;
      $display("FAIL pt_data_rd: got %h/%0d want 0/5", mem_wb_o.mem_data, mem_wb_o.rd_addr); end
    total++; if (mem_wb_o.alu_result !== 32'h1234 || mem_wb_o.pc_plus4 !== 32'h104 ||
                 mem_wb_o.opcode !== OPC_ADD) begin bad++;
      $display("FAIL pt_fields: got %h/%h/%h want 1234/104/33", mem_wb_o.alu_result,
               mem_wb_o.pc_plus4, mem_wb_o.opcode); end
    tick();
    total++; if (mem_wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL pt_drain: got %b want 0", mem_wb_valid_o); end
  endtask

  task automatic test_stores();
    send(OPC_STORE, 3'b000, 32'h1003, 32'h0000_00AB, 5'd7);
    total++; if (dc_req_valid_o !== 1'b1 || dc_we_o !== 1'b1) begin bad++;
      $display("FAIL sb_req: got %b%b want 11", dc_req_valid_o, dc_we_o); end
    total++; if (dc_addr_o !== 32'h1000) begin bad++;
      $display("FAIL sb_addr: got %h want 00001000", dc_addr_o); end
    total++; if (dc_wdata_o !== 32'hABAB_ABAB || dc_wstrb_o !== 4'b1000) begin bad++;
      $display("FAIL sb_lanes: got %h/%b want abababab/1000", dc_wdata_o, dc_wstrb_o); end
    serve(32'h0);
    total++; if (mem_wb_valid_o !== 1'b1 || mem_wb_o.rd_addr !== 5'd0) begin bad++;
      $display("FAIL sb_out: got %b/%0d want 1/0", mem_wb_valid_o, mem_wb_o.rd_addr); end
    tick();
    send(OPC_STORE, 3'b001, 32'h1002, 32'h1234_BEEF, 5'd8);
    total++; if (dc_wdata_o !== 32'hBEEF_BEEF || dc_wstrb_o !== 4'b1100) begin bad++;
      $display("FAIL sh_lanes: got %h/%b want beefbeef/1100", dc_wdata_o, dc_wstrb_o); end
    serve(32'h0);
    tick();
  endtask

  task automatic test_loads();
    for (int i = 0; i < 7; i++) begin
      send(OPC_LOAD, ld_f3[i], ld_addr[i], 32'hFFFF_FFFF, 5'd3);
      total++; if (dc_req_valid_o !== 1'b1 || dc_we_o !== 1'b0 || dc_addr_o !== 32'h2000)
      begin bad++;
        $display("FAIL ld%0d_req: got %b%b/%h want 10/00002000", i, dc_req_valid_o, dc_we_o,
                 dc_addr_o); end
      serve(32'h80FF_7F01);
      total++; if (mem_wb_valid_o !== 1'b1 || mem_wb_o.mem_data !== ld_exp[i] ||
                   mem_wb_o.rd_addr !== 5'd3) begin bad++;
        $display("FAIL ld%0d_data: got %b/%h/%0d want 1/%h/3", i, mem_wb_valid_o,
                 mem_wb_o.mem_data, mem_wb_o.rd_addr, ld_exp[i]); end
      tick();
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 5; i++) begin
      send(bad_op[i], bad_f3[i], bad_addr[i], 32'h55, 5'd9);
      total++; if (misalign_o !== 1'b1 || dc_req_valid_o !== 1'b0) begin bad++;
        $display("FAIL mis%0d_pulse: got %b/%b want 1/0", i, misalign_o, dc_req_valid_o); end
      total++; if (mem_wb_valid_o !== 1'b1 || mem_wb_o.rd_addr !== 5'd0 ||
                   mem_wb_o.mem_data !== 32'h0) begin bad++;
        $display("FAIL mis%0d_out: got %b/%0d/%h want 1/0/0", i, mem_wb_valid_o,
                 mem_wb_o.rd_addr, mem_wb_o.mem_data); end
      tick();
      total++; if (misalign_o !== 1'b0 || mem_wb_valid_o !== 1'b0) begin bad++;
        $display("FAIL mis%0d_end: got %b/%b want 0/0", i, misalign_o, mem_wb_valid_o); end
    end
  endtask

  task automatic test_back_to_back();
    send(OPC_STORE, 3'b010, 32'h3000, 32'hDEAD_BEEF, 5'd1);
    for (int i = 0; i < 3; i++) begin
      total++; if (dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h3000 ||
                   dc_wdata_o !== 32'hDEAD_BEEF || dc_wstrb_o !== 4'b1111 ||
                   exe_mem_ready_o !== 1'b0) begin bad++;
        $display("FAIL stall_req%0d: got %b/%h/%h/%b/%b want 1/3000/deadbeef/1111/0", i,
                 dc_req_valid_o, dc_addr_o, dc_wdata_o, dc_wstrb_o, exe_mem_ready_o); end
      tick();
    end
    mem_wb_ready_i = 1'b0;
    serve(32'h0);
    for (int i = 0; i < 2; i++) begin
      total++; if (mem_wb_valid_o !== 1'b1 || exe_mem_ready_o !== 1'b0 ||
                   mem_wb_o.alu_result !== 32'h3000) begin bad++;
        $display("FAIL stall_out%0d: got %b/%b/%h want 1/0/3000", i, mem_wb_valid_o,
                 exe_mem_ready_o, mem_wb_o.alu_result); end
      tick();
    end
    drive(OPC_ADD, 3'b000, 32'h55, 32'h0, 5'd6);
    mem_wb_ready_i = 1'b1;
    #1;
    total++; if (exe_mem_ready_o !== 1'b1) begin bad++;
      $display("FAIL b2b_ready: got %b want 1", exe_mem_ready_o); end
    tick();
    exe_mem_valid_i = 1'b0;
    total++; if (mem_wb_valid_o !== 1'b1 || mem_wb_o.alu_result !== 32'h55 ||
                 mem_wb_o.rd_addr !== 5'd6) begin bad++;
      $display("FAIL b2b_out: got %b/%h/%0d want 1/55/6", mem_wb_valid_o,
               mem_wb_o.alu_result, mem_wb_o.rd_addr); end
    tick();
    total++; if (mem_wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL b2b_drain: got %b want 0", mem_wb_valid_o); end
  endtask

  task automatic test_reset_mid();
    send(OPC_LOAD, 3'b010, 32'h2000, 32'h0, 5'd4);
    total++; if (dc_req_valid_o !== 1'b1) begin bad++;
      $display("FAIL rmid_req: got %b want 1", dc_req_valid_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (dc_req_valid_o !== 1'b0 || dc_addr_o !== 32'h0 || mem_wb_o !== '0) begin bad++;
      $display("FAIL rmid_async: got %b/%h/%h want 0/0/0", dc_req_valid_o, dc_addr_o,
               mem_wb_o); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (exe_mem_ready_o !== 1'b1 || mem_wb_valid_o !== 1'b0) begin bad++;
      $display("FAIL rmid_release: got %b/%b want 1/0", exe_mem_ready_o, mem_wb_valid_o); end
    // Reset while waiting for the response; a late response must be ignored.
    send(OPC_LOAD, 3'b010, 32'h2000, 32'h0, 5'd4);
    dc_req_ready_i = 1'b1;
    tick();
    dc_req_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (mem_wb_valid_o !== 1'b0 || exe_mem_ready_o !== 1'b1) begin bad++;
      $display("FAIL rwait_async: got %b/%b want 0/1", mem_wb_valid_o, exe_mem_ready_o); end
    tick();
    rst = 1'b0;
    dc_resp_valid_i = 1'b1;
    dc_rdata_i      = 32'h1234_5678;
    tick();
    dc_resp_valid_i = 1'b0;
    total++; if (mem_wb_valid_o !== 1'b0 || exe_mem_ready_o !== 1'b1) begin bad++;
      $display("FAIL rwait_ignore: got %b/%b want 0/1", mem_wb_valid_o, exe_mem_ready_o); end
  endtask

  initial begin
    rst              = 1'b1;
    exe_mem_i        = '0;
    exe_mem_funct3_i = 3'b000;
    exe_mem_valid_i  = 1'b0;
    dc_req_ready_i   = 1'b0;
    dc_resp_valid_i  = 1'b0;
    dc_rdata_i       = 32'h0;
    mem_wb_ready_i   = 1'b1;
    #12;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_passthrough();
    test_stores();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
